fp_mul_arbiter: RTL and testbench
=================================

// Module: fp_mul_arbiter
// PURPOSE
//  Shares one 32-bit FP multiplier datapath between NREQ requesters.
//  Round-robin arbitration, operand capture, multiplier sequencing (load -> start -> wait done), result return.
//  Sits between the requesting units and the multiplier core; the core's own control only sees mul_load/mul_start.
// PARAMETERS
//  NREQ        4    number of requesters (2..8)
//  TIMEOUT_CYC 64   watchdog limit in WAIT cycles (used only with FPMUL_WDOG_EN)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  req          in   NREQ      per-requester request level
//  req_a        in   NREQ*32   operand A, requester i at [32*i+:32]
//  req_b        in   NREQ*32   operand B, same packing
//  gnt          out  NREQ      one-hot grant pulse
//  resp_valid   out  NREQ      one-hot result-valid pulse
//  resp_result  out  32        product to granted requester
//  resp_err     out  1         watchdog expiry flag, qualified by resp_valid
//  busy         out  1         high in any state other than IDLE
//  mul_a        out  32        operand A to multiplier
//  mul_b        out  32        operand B to multiplier
//  mul_load     out  1         operand load strobe
//  mul_start    out  1         start strobe
//  mul_done     in   1         multiplier completion (level or pulse)
//  mul_result   in   32        multiplier product, valid while mul_done=1
// BEHAVIOUR
//  - All outputs registered.
//  - Reset (async, any state incl. mid-operation):
//    state=IDLE; gnt, resp_valid, mul_load, mul_start, busy, resp_err = 0
//    mul_a, mul_b, resp_result = 0; rr_ptr = NREQ-1, so req[0] wins first
//    A multiply in flight is abandoned; no resp_valid is issued for it.
//  - FSM (3-bit): IDLE -> LOAD -> START -> WAIT -> RESP -> IDLE
//    IDLE:  if |req, winner = first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
//           Capture winner's req_a/req_b into mul_a/mul_b at that edge; go LOAD. Else stay.
//    LOAD:  gnt[winner]=1, mul_load=1 for exactly this cycle; go START.
//    START: mul_start=1 for exactly this cycle; go WAIT.
//    WAIT:  if mul_done, capture mul_result into resp_result; go RESP. Else stay.
//    RESP:  resp_valid[winner]=1 for one cycle; rr_ptr=winner; go IDLE.
//  - mul_done is sampled only in WAIT; ignored in all other states.
//  - mul_a/mul_b are held stable from the LOAD cycle until the next capture.
//  - resp_result holds its value until the next RESP.
//  - Requester holds req and operands until it sees gnt, then may drop req.
//  - req still high in the cycle after its resp_valid counts as a new request.
//  - Latency: req high in IDLE cycle 0 -> LOAD 1, START 2, earliest WAIT 3.
//    mul_done in cycle 3 -> resp_valid in cycle 4.
//    Total = 4 + extra WAIT cycles.
//  - Throughput: one operation per 5+ cycles; no overlap, no queuing.
//  - Arbitration is re-evaluated only in IDLE. Requests arriving mid-op wait.
//  - Single requester active: it is served back-to-back with no penalty.
// CONFIGURATION
//  FPMUL_WDOG_EN defined:
//    - 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
//    - When count reaches TIMEOUT_CYC-1 without mul_done: go RESP with
//      resp_result=32'h7FC00000 (qNaN) and resp_err=1 for that RESP cycle.
//    - mul_done in the same cycle as expiry wins: normal result, resp_err=0.
//  FPMUL_WDOG_EN undefined:
//    - No counter; WAIT waits indefinitely.
//    - resp_err tied 0.
// TESTING
//  1 Reset: rst_n low mid-WAIT -> all outputs 0 and state IDLE immediately.
//    Release -> no resp_valid for the abandoned op.
//  2 Single op: req=4'b0001, A=3F800000, B=40000000, mul_done 2 cycles after start
//    -> gnt=0001 at c1, mul_start at c2, resp_valid=0001 at c5, resp_result=40000000.
//  3 Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0. Each op completes before the next gnt.
//  4 Wrap/skip: rr_ptr=3, req=4'b0100 -> grant 2. Then req=4'b0101 -> grant 0.
//  5 Stray done: mul_done pulsed in IDLE, LOAD and START -> ignored; FSM still waits in WAIT.
//  6 FPMUL_WDOG_EN, TIMEOUT_CYC=64, mul_done never asserted
//    -> resp_valid after 64 WAIT cycles, resp_result=7FC00000, resp_err=1.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that shares one 32-bit FP multiplier among NREQ requesters.
// Optional watchdog on the multiplier wait is enabled by defining FPMUL_WDOG_EN.
module fp_mul_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_result,
  output logic                 resp_err,
  output logic                 busy,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_load,
  output logic                 mul_start,
  input  logic                 mul_done,
  input  logic [31:0]          mul_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   rr_ptr_reg;
  logic [IW-1:0]   winner_reg;
  logic [IW-1:0]   winner_next;
  logic [31:0]     op_a [NREQ];
  logic [31:0]     op_b [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[32*gi +: 32];
      assign op_b[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // Scan from farthest to nearest so the first set bit after rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    winner_next = rr_ptr_reg;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (req[idx]) winner_next = IW'(idx);
    end
  end

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

`ifdef FPMUL_WDOG_EN
  logic [7:0] wdog_cnt_reg;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      rr_ptr_reg  <= IW'(NREQ - 1);
      winner_reg  <= '0;
      gnt         <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      busy        <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_load    <= 1'b0;
      mul_start   <= 1'b0;
`ifdef FPMUL_WDOG_EN
      resp_err     <= 1'b0;
      wdog_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|req) begin
            winner_reg <= winner_next;
            mul_a      <= op_a[winner_next];
            mul_b      <= op_b[winner_next];
            gnt        <= onehot(winner_next);
            mul_load   <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= S_LOAD;
          end
        end
        S_LOAD: begin
          gnt       <= '0;
          mul_load  <= 1'b0;
          mul_start <= 1'b1;
          state_reg <= S_START;
        end
        S_START: begin
          mul_start <= 1'b0;
          state_reg <= S_WAIT;
`ifdef FPMUL_WDOG_EN
          wdog_cnt_reg <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_done) begin
            resp_result <= mul_result;
            resp_valid  <= onehot(winner_reg);
            state_reg   <= S_RESP;
`ifdef FPMUL_WDOG_EN
            resp_err    <= 1'b0;
          end else if (wdog_cnt_reg == 8'(TIMEOUT_CYC - 1)) begin
            // Expired: hand back a quiet NaN so the requester is never stranded.
            resp_result <= QNAN;
            resp_err    <= 1'b1;
            resp_valid  <= onehot(winner_reg);
            state_reg   <= S_RESP;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 8'd1;
`endif
          end
        end
        S_RESP: begin
          resp_valid <= '0;
          rr_ptr_reg <= winner_reg;
          busy       <= 1'b0;
          state_reg  <= S_IDLE;
`ifdef FPMUL_WDOG_EN
          resp_err   <= 1'b0;
`endif
        end
        default: begin
          gnt        <= '0;
          resp_valid <= '0;
          mul_load   <= 1'b0;
          mul_start  <= 1'b0;
          busy       <= 1'b0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter; the bench plays the multiplier core.
// Define FPMUL_WDOG_EN for both files to exercise the watchdog timeout.
module tb_fp_mul_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]   gnt, resp_valid;
  logic [31:0]       resp_result, mul_a, mul_b, mul_result;
  logic              resp_err, busy, mul_load, mul_start, mul_done;

  int n_cmp = 0;
  int n_err = 0;

  fp_mul_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
    .mul_load(mul_load), .mul_start(mul_start), .mul_done(mul_done),
    .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [31:0] a_of(input int i);
    return 32'h3F80_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] b_of(input int i);
    return 32'h4000_0000 + 32'(i);
  endfunction

  // Entered at the negedge of an IDLE cycle with req already applied; returns at the RESP negedge.
  task automatic do_op(input string tag, input int w, input int extra,
                       input logic [31:0] res, input bit drop);
    @(negedge clk);
    check({tag, " gnt"}, 32'(gnt), 32'(1 << w));
    check({tag, " mul_load"}, 32'(mul_load), 32'd1);
    check({tag, " mul_a"}, mul_a, a_of(w));
    check({tag, " mul_b"}, mul_b, b_of(w));
    if (drop) req = '0;
    @(negedge clk);
    check({tag, " mul_start"}, 32'(mul_start), 32'd1);
    check({tag, " gnt_clr"}, 32'(gnt), 32'd0);
    @(negedge clk);
    repeat (extra) @(negedge clk);
    mul_done   = 1'b1;
    mul_result = res;
    @(negedge clk);
    mul_done = 1'b0;
    check({tag, " resp_valid"}, 32'(resp_valid), 32'(1 << w));
    check({tag, " resp_result"}, resp_result, res);
    check({tag, " resp_err"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    mul_done   = 1'b0;
    mul_result = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = a_of(i);
      req_b[32*i +: 32] = b_of(i);
    end
    repeat (2) @(negedge clk);
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst mul_load", 32'(mul_load), 32'd0);
    check("rst mul_start", 32'(mul_start), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mul_a", mul_a, 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Wrap/skip from rr_ptr=3: 0100 -> 2, then 0101 -> 0.
    req = 4'b0100;
    do_op("skip2", 2, 0, 32'h4080_0000, 1'b1);
    @(negedge clk);
    req = 4'b0101;
    do_op("wrap0", 0, 0, 32'h40A0_0000, 1'b1);
    @(negedge clk);

    // Single op: done two cycles after start, resp_valid at c5.
    req = 4'b0001;
    req_a[31:0] = 32'h3F80_0000;
    req_b[31:0] = 32'h4000_0000;
    do_op("single", 0, 1, 32'h4000_0000, 1'b1);
    @(negedge clk);
    check("single idle busy", 32'(busy), 32'd0);
    check("single idle resp_valid", 32'(resp_valid), 32'd0);

    // Async reset mid-WAIT abandons the op.
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check("midwait busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst gnt", 32'(gnt), 32'd0);
    check("arst mul_a", mul_a, 32'd0);
    check("arst resp_result", resp_result, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    mul_done   = 1'b1;
    mul_result = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      check("abandoned resp_valid", 32'(resp_valid), 32'd0);
      check("abandoned busy", 32'(busy), 32'd0);
    end
    mul_done = 1'b0;

    // Round-robin with all requests held: 0,1,2,3,0.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      do_op("rr", k % NREQ, k % 3, 32'h4100_0000 + 32'(k), 1'b0);
      @(negedge clk);
      check("rr idle gnt", 32'(gnt), 32'd0);
      check("rr idle busy", 32'(busy), 32'd0);
      if (k == 4) req = '0;
    end
    @(negedge clk);

    // Stray mul_done in IDLE, LOAD and START is ignored.
    mul_done   = 1'b1;
    mul_result = 32'h1234_5678;
    @(negedge clk);
    check("stray idle busy", 32'(busy), 32'd0);
    req = 4'b0010;
    @(negedge clk);
    check("stray load gnt", 32'(gnt), 32'b0010);
    req = '0;
    @(negedge clk);
    check("stray start", 32'(mul_start), 32'd1);
    mul_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray wait resp_valid", 32'(resp_valid), 32'd0);
      check("stray wait busy", 32'(busy), 32'd1);
    end
    mul_done   = 1'b1;
    mul_result = 32'h3F00_0000;
    @(negedge clk);
    mul_done = 1'b0;
    check("stray resp_valid", 32'(resp_valid), 32'b0010);
    check("stray resp_result", resp_result, 32'h3F00_0000);
    @(negedge clk);

    // Multiplier never answers: watchdog fires after 64 WAIT cycles, else FSM keeps waiting.
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    repeat (63) @(negedge clk);
    check("wdog pre resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("wdog last resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
`ifdef FPMUL_WDOG_EN
    check("wdog resp_valid", 32'(resp_valid), 32'b0100);
    check("wdog resp_result", resp_result, 32'h7FC0_0000);
    check("wdog resp_err", 32'(resp_err), 32'd1);
`else
    check("nowdog resp_valid", 32'(resp_valid), 32'd0);
    check("nowdog busy", 32'(busy), 32'd1);
    mul_done   = 1'b1;
    mul_result = 32'h4040_0000;
    @(negedge clk);
    mul_done = 1'b0;
    check("nowdog late resp_valid", 32'(resp_valid), 32'b0100);
    check("nowdog late resp_result", resp_result, 32'h4040_0000);
    check("nowdog resp_err", 32'(resp_err), 32'd0);
`endif
    @(negedge clk);
    check("final busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
